// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Holds the default character width, the oversampling ratio of the baud
// generator and the derived default idle-timeout length. It also holds the
// character typedef used on the receive path.
package uart_pkg;

    localparam int UART_DBIT     = 8;   // data bits per character
    localparam int UART_OSR      = 16;  // s_tick pulses per bit time
    localparam int UART_FRAME    = UART_DBIT + 2;  // start + data + stop bits
    localparam int UART_TO_CHARS = 4;   // idle characters before timeout

    // Idle time of four whole frames, measured in oversampling ticks.
    localparam int UART_TO_TICKS = UART_TO_CHARS * UART_FRAME * UART_OSR;

    typedef logic [UART_DBIT-1:0] char_t;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array for the receive FIFO.
// Write is synchronous. Read is asynchronous, so the head entry is visible
// in the same cycle the read pointer moves (first-word-fall-through).
// Ports: clk, we/waddr/wdata (write side), raddr/rdata (read side).
module fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int DBIT   = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DBIT-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DBIT-1:0]   rdata
);

    logic [DBIT-1:0] mem_r [2**ADDR_W];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver.
// It captures each byte on rx_done_tick and presents it through a
// first-word-fall-through port. It flags dropped characters (sticky
// overrun). It raises timeout when data sits unread with no push or pop
// for TO_TICKS oversampling ticks.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   s_tick                oversampling tick (timeout time base)
//   rx_done_tick, din     received character strobe and data
//   rd                    pop request
//   clr_ovf               clear sticky overrun
//   dout                  head of FIFO, valid while empty=0
//   empty, full, almost_full, level   occupancy status
//   overrun, timeout      error / idle indications
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT     = UART_DBIT,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int TO_TICKS = UART_TO_TICKS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] din,
    input  logic            rd,
    input  logic            clr_ovf,
    output logic [DBIT-1:0] dout,
    output logic            empty,
    output logic            full,
    output logic            almost_full,
    output logic [ADDR_W:0] level,
    output logic            overrun,
    output logic            timeout
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_TICKS - 1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   level_r;
    logic [ADDR_W:0]   level_next_s;
    logic              empty_r;
    logic              full_r;
    logic              af_r;
    logic              overrun_r;
    logic              overrun_next_s;
    logic              timeout_r;
    logic              timeout_next_s;
    logic [CNT_W-1:0]  to_cnt_r;
    logic [CNT_W-1:0]  to_cnt_next_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              ovf_set_s;

    // A push into a full FIFO is accepted only when a pop frees the slot in
    // the same cycle. A pop of an empty FIFO is ignored, so an empty-cycle
    // push+pop degenerates to a push.
    assign wr_acc_s  = rx_done_tick & (~full_r | rd);
    assign rd_acc_s  = rd & ~empty_r;
    assign ovf_set_s = rx_done_tick & full_r & ~rd;

    fifo_mem #(
        .ADDR_W (ADDR_W),
        .DBIT   (DBIT)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (din),
        .raddr (rd_ptr_r),
        .rdata (dout)
    );

    // Next occupancy: simultaneous push and pop leave the level unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_next_s = level_r + (ADDR_W+1)'(1);
            2'b01:   level_next_s = level_r - (ADDR_W+1)'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Sticky overrun: a new drop takes priority over a clear in the same cycle.
    always_comb begin
        overrun_next_s = overrun_r;
        if (ovf_set_s) begin
            overrun_next_s = 1'b1;
        end else if (clr_ovf) begin
            overrun_next_s = 1'b0;
        end else begin
            overrun_next_s = overrun_r;
        end
    end

    // Idle timer: runs only while data is held and nothing moves. It
    // saturates at its last value while timeout is asserted.
    always_comb begin
        to_cnt_next_s  = to_cnt_r;
        timeout_next_s = timeout_r;
        if (wr_acc_s || rd_acc_s || empty_r) begin
            to_cnt_next_s  = {CNT_W{1'b0}};
            timeout_next_s = 1'b0;
        end else if (s_tick) begin
            if (to_cnt_r == CNT_MAX) begin
                to_cnt_next_s  = to_cnt_r;
                timeout_next_s = 1'b1;
            end else begin
                to_cnt_next_s  = to_cnt_r + CNT_W'(1);
                timeout_next_s = timeout_r;
            end
        end else begin
            to_cnt_next_s  = to_cnt_r;
            timeout_next_s = timeout_r;
        end
    end

    // State registers. The flags are registered from the next level, so they
    // stay cycle-aligned with level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {ADDR_W{1'b0}};
            rd_ptr_r  <= {ADDR_W{1'b0}};
            level_r   <= {(ADDR_W+1){1'b0}};
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            af_r      <= 1'b0;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
            to_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            level_r   <= level_next_s;
            empty_r   <= (level_next_s == (ADDR_W+1)'(0));
            full_r    <= (level_next_s == (ADDR_W+1)'(DEPTH));
            af_r      <= (level_next_s >= (ADDR_W+1)'(AF_LEVEL));
            overrun_r <= overrun_next_s;
            timeout_r <= timeout_next_s;
            to_cnt_r  <= to_cnt_next_s;
        end
    end

    assign level       = level_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign almost_full = af_r;
    assign overrun     = overrun_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int TO    = 640;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic       overrun;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    int         m_cnt = 0;
    bit         m_to = 1'b0;

    uart_rx_fifo #(
        .DBIT     (8),
        .ADDR_W   (4),
        .AF_LEVEL (AF),
        .TO_TICKS (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .rd           (rd),
        .clr_ovf      (clr_ovf),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .level        (level),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        m_to  = 1'b0;
    endtask

    task automatic model_step(input bit rx, input logic [7:0] d, input bit r, input bit c, input bit t);
        bit fullm;
        bit emptym;
        bit wacc;
        bit racc;
        fullm  = (q.size() == DEPTH);
        emptym = (q.size() == 0);
        wacc   = rx && (!fullm || r);
        racc   = r && !emptym;
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back(d);
        if (rx && fullm && !r) m_ovf = 1'b1;
        else if (c)            m_ovf = 1'b0;
        if (wacc || racc || emptym) begin
            m_cnt = 0;
            m_to  = 1'b0;
        end else if (t) begin
            if (m_cnt == TO - 1) m_to = 1'b1;
            else                 m_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ".af"},    32'(almost_full), 32'(q.size() >= AF));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".ovf"},   32'(overrun), 32'(m_ovf));
        chk({tag, ".to"},    32'(timeout), 32'(m_to));
        if (q.size() != 0) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
    endtask

    // One clock: drive inputs, advance model at the edge, sample 1 ns later.
    task automatic cycle(input bit rx, input logic [7:0] d, input bit r, input bit c, input bit t);
        rx_done_tick = rx;
        din          = d;
        rd           = r;
        clr_ovf      = c;
        s_tick       = t;
        @(posedge clk);
        model_step(rx, d, r, c, t);
        #1;
        rx_done_tick = 1'b0;
        rd           = 1'b0;
        clr_ovf      = 1'b0;
        s_tick       = 1'b0;
        check_all("cyc");
    endtask

    initial begin
        int p_rx;
        int p_rd;
        logic [7:0] last;

        // reset
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.af", 32'(almost_full), 32'd0);
        chk("rst.ovf", 32'(overrun), 32'd0);
        chk("rst.to", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 1: single byte in and out
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("t1.empty", 32'(empty), 32'd0);
        chk("t1.level", 32'(level), 32'd1);
        chk("t1.dout", 32'(dout), 32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t1.empty_after", 32'(empty), 32'd1);
        chk("t1.level_after", 32'(level), 32'd0);

        // 2: fill 0x00..0x0F, almost_full from the 12th write, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk("t2.af", 32'(almost_full), 32'(i + 1 >= 12));
        end
        chk("t2.full", 32'(full), 32'd1);
        chk("t2.level", 32'(level), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2.pop", 32'(dout), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("t2.empty", 32'(empty), 32'd1);

        // 3: overrun, clear, set-beats-clear
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("t3.ovf", 32'(overrun), 32'd1);
        chk("t3.level", 32'(level), 32'd16);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t3.clr", 32'(overrun), 32'd0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
        chk("t3.set_wins", 32'(overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3.order", 32'(dout), 32'(8'h10 + i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t3.clr2", 32'(overrun), 32'd0);

        // 4: push+pop while full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("t4.level", 32'(level), 32'd16);
        chk("t4.ovf", 32'(overrun), 32'd0);
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last = dout;
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("t4.last", 32'(last), 32'h55);

        // 5: push+pop while empty
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("t5.level", 32'(level), 32'd1);
        chk("t5.dout", 32'(dout), 32'h3C);

        // 6: timeout on exactly the 640th tick (one byte already held)
        for (int k = 1; k <= TO; k++) begin
            repeat (15) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (k >= TO - 1) chk("t6.to_edge", 32'(timeout), 32'(k == TO));
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t6.to_clear", 32'(timeout), 32'd0);

        // async reset mid-fill at level 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        chk("rst2.pre", 32'(level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.level", 32'(level), 32'd0);
        chk("rst2.empty", 32'(empty), 32'd1);
        chk("rst2.to", 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // randomized traffic in three pressure phases
        for (int ph = 0; ph < 3; ph++) begin
            p_rx = (ph == 0) ? 70 : (ph == 1) ? 40 : 85;
            p_rd = (ph == 0) ? 30 : (ph == 1) ? 60 : 50;
            for (int n = 0; n < 800; n++) begin
                cycle($urandom_range(0, 99) < p_rx,
                      8'($urandom),
                      $urandom_range(0, 99) < p_rd,
                      $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < 50);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures each received byte on the receiver's one-cycle done pulse and stores it in a circular FIFO. Presents the bytes to the host/bus side through a first-word-fall-through read port. Adds overrun detection and a character-timeout indication, so the host can drain partial bursts.

Parameters:
DBIT, 8, data bits per character (must match receiver DBIT)
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (16)
AF_LEVEL, 12, level at or above which almost_full asserts (1..2**ADDR_W)
TO_TICKS, 640, s_tick count of write/read inactivity, with data held, before timeout (default = 4 chars x 10 bits x 16 ticks)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
s_tick  in  1  oversampling tick from baud generator, one clk wide
rx_done_tick  in  1  one-cycle pulse from receiver: din valid this cycle
din  in  DBIT  received character
rd  in  1  host read/pop request, one clk per pop
clr_ovf  in  1  clear sticky overrun flag
dout  out  DBIT  head-of-FIFO character, valid whenever empty=0 (FWFT)
empty  out  1  FIFO holds no data
full  out  1  FIFO holds 2**ADDR_W entries
almost_full  out  1  level >= AF_LEVEL
level  out  ADDR_W+1  number of stored entries, 0..2**ADDR_W
overrun  out  1  sticky: a character was dropped
timeout  out  1  data held and no activity for TO_TICKS s_ticks

Behaviour:
- Reset (rst_n=0, async): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, almost_full=0, overrun=0, timeout=0, timeout counter=0. dout=0 is not guaranteed and not checked while empty. Memory contents are not reset.
- Pointers: ADDR_W bits, natural wrap from 2**ADDR_W-1 to 0. Level is held in a separate ADDR_W+1-bit register. empty, full and almost_full are derived from level (registered or combinational from the level register; no extra latency).
- Write accept: rx_done_tick=1 and (full=0 or rd=1). On accept, mem[wr_ptr]<=din and wr_ptr++.
- Read accept: rd=1 and empty=0. On accept, rd_ptr++. rd while empty is ignored, with no state change.
- Level update per cycle:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both or neither are accepted.
- Simultaneous write+read while empty: only the write is accepted (read ignored). Level becomes 1.
- Simultaneous write+read while full: both are accepted. Level stays 2**ADDR_W. The old head is popped and the new byte is stored at the vacated slot.
- FWFT latency: a byte written into an empty FIFO appears on dout with empty=0 on the next clk edge (1 cycle). After a pop, dout shows the next entry in the same cycle that rd_ptr updates. dout = mem[rd_ptr] (async read or equivalent).
- Overrun: rx_done_tick=1, full=1 and rd=0 means the byte is dropped, storage is unchanged, and overrun<=1 next cycle. overrun stays high until clr_ovf=1. If set and clear occur in the same cycle, set wins.
- Timeout counter (range 0..TO_TICKS-1, saturating):
  - Cleared to 0 and timeout<=0 when any write or read is accepted, or when the FIFO is empty.
  - Otherwise it increments on each s_tick.
  - When s_tick=1 and the count is TO_TICKS-1, timeout<=1 and the count holds.
  - timeout remains 1 until the next accepted read/write (or the FIFO empties).
- Reset mid-operation: all state returns to reset values immediately. In-flight rx_done_tick is lost.

Decomposition:
- Shared package uart_pkg holds:
  - DBIT default constant.
  - Oversampling constant (16 ticks/bit).
  - A char_t typedef (logic [DBIT-1:0]).
- TO_TICKS default is derived from the package constants.
- One sub-module is natural: fifo_mem (ADDR_W, DBIT), a dual-port register array with sync write and async read. Pointer, level, flag and timeout logic stay in uart_rx_fifo.

Test Plan:
1. Reset then write 0xA5 via rx_done_tick -> next cycle empty=0, level=1, dout=0xA5; pulse rd -> empty=1, level=0.
2. Write 16 bytes 0x00..0x0F -> full=1, level=16, almost_full=1 from the 12th write onward; pop all 16 -> dout sequence 0x00..0x0F in order, empty=1.
3. Fill to 16, write 0xEE with rd=0 -> overrun=1, level=16, pop order is unchanged (0xEE absent). Pulse clr_ovf -> overrun=0. Assert clr_ovf with a second overrun in the same cycle -> overrun stays 1.
4. Full FIFO, rx_done_tick=1 with din=0x55 and rd=1 in the same cycle -> level=16, no overrun; after draining, last byte read is 0x55.
5. Empty FIFO, rx_done_tick and rd in the same cycle with din=0x3C -> level=1, dout=0x3C.
6. Write one byte, then supply s_tick every 16 clk with TO_TICKS=640 -> timeout=1 exactly on the 640th s_tick; rd -> timeout=0. Assert rst_n=0 mid-fill at level=5 -> level=0, empty=1, timeout=0 asynchronously.
